// File: rtl/ddr_ctrl_pkg.sv
// rtl/ddr_ctrl_pkg.sv - shared DDR controller types and timing defaults
package ddr_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_PRE  = 3'd3,
    CMD_PREA = 3'd4
  } cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PRE, ST_WAIT_RP, ST_ACT, ST_WAIT_RCD,
    ST_RD, ST_WAIT_CL, ST_BURST, ST_PREA, ST_WAIT_RPA
  } rd_state_t;

  localparam int DEF_NUM_BANKS = 8;
  localparam int DEF_ROW_W     = 14;
  localparam int DEF_COL_W     = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_T_RCD     = 3;
  localparam int DEF_T_RP      = 3;
  localparam int DEF_CL        = 5;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bank_row_table.sv
// rtl/bank_row_table.sv - per-bank open-row register file
module bank_row_table #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 14,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BANK_W-1:0] lookup_bank,
  input  logic [ROW_W-1:0]  lookup_row,
  output logic              lookup_open,
  output logic              lookup_hit,
  input  logic              open_en,
  input  logic [BANK_W-1:0] open_bank,
  input  logic [ROW_W-1:0]  open_row,
  input  logic              close_en,
  input  logic [BANK_W-1:0] close_bank,
  input  logic              close_all
);

  logic [NUM_BANKS-1:0] valid;
  logic [ROW_W-1:0]     row_q [NUM_BANKS];

  assign lookup_open = valid[lookup_bank];
  assign lookup_hit  = valid[lookup_bank] && (row_q[lookup_bank] == lookup_row);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else if (close_all) begin
      valid <= '0;
    end else begin
      if (open_en) begin
        valid[open_bank] <= 1'b1;
        row_q[open_bank] <= open_row;
      end
      if (close_en) valid[close_bank] <= 1'b0;
    end
  end

endmodule

// File: rtl/read_seq_fsm.sv
// rtl/read_seq_fsm.sv - open-page DDR read sequencer (ACT/RD/PRE/PREA + burst capture)
module read_seq_fsm import ddr_ctrl_pkg::*; #(
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP,
  parameter int CL        = DEF_CL,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  input  logic              ref_req,
  output logic              ref_ack,
  output logic [2:0]        cmd,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0] phy_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last
);

  localparam int CNT_W = $clog2(max4(T_RCD, T_RP, CL, BURST_LEN) + 1);
  localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RCD_LOAD  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] CL_LOAD   = CNT_W'(CL - 1);
  localparam logic [CNT_W-1:0] RPA_LOAD  = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] BEAT_LOAD = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  rd_state_t         state, state_nxt;
  cmd_t              cmd_c;
  logic [CNT_W-1:0]  wait_cnt, beat_cnt;
  logic [BANK_W-1:0] lat_bank;
  logic [ROW_W-1:0]  lat_row;
  logic [COL_W-1:0]  lat_col;
  logic              lk_open, lk_hit;
  logic              tbl_open, tbl_close, tbl_close_all;

  // Lookup only matters in IDLE, where the incoming request is classified.
  bank_row_table #(.NUM_BANKS(NUM_BANKS), .ROW_W(ROW_W)) u_rows (
    .clk        (clk),
    .rst        (rst),
    .lookup_bank(req_bank),
    .lookup_row (req_row),
    .lookup_open(lk_open),
    .lookup_hit (lk_hit),
    .open_en    (tbl_open),
    .open_bank  (lat_bank),
    .open_row   (lat_row),
    .close_en   (tbl_close),
    .close_bank (lat_bank),
    .close_all  (tbl_close_all)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_bank <= '0;
      lat_row  <= '0;
      lat_col  <= '0;
    end else if (req_valid && req_ready) begin
      lat_bank <= req_bank;
      lat_row  <= req_row;
      lat_col  <= req_col;
    end
  end

  // Counters load on state entry and only count down while non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        ST_WAIT_RP:  wait_cnt <= RP_LOAD;
        ST_WAIT_RCD: wait_cnt <= RCD_LOAD;
        ST_WAIT_CL:  wait_cnt <= CL_LOAD;
        ST_WAIT_RPA: wait_cnt <= RPA_LOAD;
        default:     wait_cnt <= '0;
      endcase
      beat_cnt <= (state_nxt == ST_BURST) ? BEAT_LOAD : '0;
    end else begin
      if (wait_cnt != '0) wait_cnt <= wait_cnt - ONE;
      if (beat_cnt != '0) beat_cnt <= beat_cnt - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= (state == ST_BURST);
      rd_last  <= (state == ST_BURST) && (beat_cnt == '0);
      if (state == ST_BURST) rd_data <= phy_rdata;
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_c         = CMD_NOP;
    cmd_bank      = '0;
    cmd_addr      = '0;
    req_ready     = 1'b0;
    ref_ack       = 1'b0;
    tbl_open      = 1'b0;
    tbl_close     = 1'b0;
    tbl_close_all = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = !ref_req;
        if (ref_req)          state_nxt = ST_PREA;
        else if (req_valid) begin
          if (!lk_open)       state_nxt = ST_ACT;
          else if (lk_hit)    state_nxt = ST_RD;
          else                state_nxt = ST_PRE;
        end
      end
      ST_PRE: begin
        cmd_c     = CMD_PRE;
        cmd_bank  = lat_bank;
        tbl_close = 1'b1;
        state_nxt = (T_RP > 1) ? ST_WAIT_RP : ST_ACT;
      end
      ST_WAIT_RP:  if (wait_cnt <= ONE) state_nxt = ST_ACT;
      ST_ACT: begin
        cmd_c     = CMD_ACT;
        cmd_bank  = lat_bank;
        cmd_addr  = lat_row;
        tbl_open  = 1'b1;
        state_nxt = (T_RCD > 1) ? ST_WAIT_RCD : ST_RD;
      end
      ST_WAIT_RCD: if (wait_cnt <= ONE) state_nxt = ST_RD;
      ST_RD: begin
        cmd_c     = CMD_RD;
        cmd_bank  = lat_bank;
        cmd_addr  = ROW_W'(lat_col);
        state_nxt = (CL > 1) ? ST_WAIT_CL : ST_BURST;
      end
      ST_WAIT_CL:  if (wait_cnt <= ONE) state_nxt = ST_BURST;
      ST_BURST:    if (beat_cnt == '0) state_nxt = ST_IDLE;
      ST_PREA: begin
        cmd_c         = CMD_PREA;
        tbl_close_all = 1'b1;
        state_nxt     = ST_WAIT_RPA;
      end
      ST_WAIT_RPA: begin
        if (wait_cnt <= ONE) begin
          ref_ack   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd = cmd_c;

endmodule

// File: tb/tb_read_seq_fsm.sv
// tb/tb_read_seq_fsm.sv - scoreboard bench for read_seq_fsm (default and minimum-latency builds)
module tb_read_seq_fsm;
  import ddr_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } ev_t;

  localparam int K_BEAT = 5, K_LAST = 6, K_ACK = 7, K_READY = 8;

  logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic        req_valid = 1'b0, ref_req = 1'b0;
  logic [2:0]  req_bank = '0;
  logic [13:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic [31:0] phy_rdata;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          t_rcd, t_rp, cl, bl, last_end;
  ev_t         obs_q[$], exp_q[$];
  logic        prev_ready = 1'b0;

  logic        a_req_ready, a_ref_ack, a_rd_valid, a_rd_last;
  logic [2:0]  a_cmd, a_cmd_bank;
  logic [13:0] a_cmd_addr;
  logic [31:0] a_rd_data;
  logic        b_req_ready, b_ref_ack, b_rd_valid, b_rd_last;
  logic [2:0]  b_cmd;
  logic [1:0]  b_cmd_bank;
  logic [13:0] b_cmd_addr;
  logic [31:0] b_rd_data;
  logic        m_req_ready, m_ref_ack, m_rd_valid, m_rd_last;
  logic [2:0]  m_cmd, m_cmd_bank;
  logic [13:0] m_cmd_addr;
  logic [31:0] m_rd_data;

  function automatic logic [31:0] pdata(input int c);
    return 32'hD5A0_0000 ^ (32'(c) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] ev_val(input logic [2:0] b, input logic [13:0] a);
    return {13'b0, b, 2'b0, a};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign phy_rdata = pdata(cyc);

  read_seq_fsm u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req & ~sel), .ref_ack(a_ref_ack), .cmd(a_cmd), .cmd_bank(a_cmd_bank),
    .cmd_addr(a_cmd_addr), .phy_rdata(phy_rdata), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .rd_last(a_rd_last)
  );

  read_seq_fsm #(.NUM_BANKS(4), .BURST_LEN(1), .CL(1), .T_RCD(1), .T_RP(1)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_bank(req_bank[1:0]), .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req & sel), .ref_ack(b_ref_ack), .cmd(b_cmd), .cmd_bank(b_cmd_bank),
    .cmd_addr(b_cmd_addr), .phy_rdata(phy_rdata), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .rd_last(b_rd_last)
  );

  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_ref_ack   = sel ? b_ref_ack : a_ref_ack;
  assign m_rd_valid  = sel ? b_rd_valid : a_rd_valid;
  assign m_rd_last   = sel ? b_rd_last : a_rd_last;
  assign m_cmd       = sel ? b_cmd : a_cmd;
  assign m_cmd_bank  = sel ? {1'b0, b_cmd_bank} : a_cmd_bank;
  assign m_cmd_addr  = sel ? b_cmd_addr : a_cmd_addr;
  assign m_rd_data   = sel ? b_rd_data : a_rd_data;

  // Monitor: every observable DUT event lands in obs_q, tagged with its cycle.
  always @(negedge clk) begin
    if (m_cmd != 3'd0) obs_q.push_back('{cyc, int'(m_cmd), ev_val(m_cmd_bank, m_cmd_addr)});
    if (m_rd_valid || m_rd_last) obs_q.push_back('{cyc, (m_rd_last ? K_LAST : K_BEAT), m_rd_data});
    if (m_ref_ack) obs_q.push_back('{cyc, K_ACK, 32'd0});
    if (m_req_ready && !prev_ready) obs_q.push_back('{cyc, K_READY, 32'd0});
    prev_ready <= m_req_ready;
  end

  task automatic set_sel(input logic s);
    @(negedge clk);
    #2;
    sel   = s;
    t_rcd = s ? 1 : 3;
    t_rp  = s ? 1 : 3;
    cl    = s ? 1 : 5;
    bl    = s ? 1 : 8;
  endtask

  // mode: 0 row hit, 1 bank closed, 2 row miss
  task automatic push_read(input int acc, input int mode, input logic [2:0] b,
                           input logic [13:0] r, input logic [9:0] c, input int nbeats);
    int t;
    t = acc + 1;
    if (mode == 2) begin exp_q.push_back('{t, int'(CMD_PRE), ev_val(b, 14'd0)}); t += t_rp; end
    if (mode >= 1) begin exp_q.push_back('{t, int'(CMD_ACT), ev_val(b, r)}); t += t_rcd; end
    exp_q.push_back('{t, int'(CMD_RD), ev_val(b, {4'b0, c})});
    for (int i = 0; i < nbeats; i++)
      exp_q.push_back('{t + cl + 1 + i, ((i == bl - 1) ? K_LAST : K_BEAT), pdata(t + cl + i)});
    if (nbeats == bl) exp_q.push_back('{t + cl + bl, K_READY, 32'd0});
    last_end = t + cl + bl;
  endtask

  task automatic present(input logic [2:0] b, input logic [13:0] r, input logic [9:0] c,
                         output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!m_req_ready) begin
      errors++;
      $display("FAIL present_timeout req_ready=%0b required=1", m_req_ready);
    end
    #2;
    req_valid = 1'b1; req_bank = b; req_row = r; req_col = c;
    acc = cyc;
    @(negedge clk);
    #2 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (m_cmd !== 3'd0)       begin errors++; $display("FAIL reset_cmd got %0d required 0", m_cmd); end
    if (m_cmd_bank !== 3'd0)  begin errors++; $display("FAIL reset_cmd_bank got %0d required 0", m_cmd_bank); end
    if (m_cmd_addr !== 14'd0) begin errors++; $display("FAIL reset_cmd_addr got %h required 0", m_cmd_addr); end
    if (m_rd_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid got %b required 0", m_rd_valid); end
    if (m_rd_last !== 1'b0)   begin errors++; $display("FAIL reset_rd_last got %b required 0", m_rd_last); end
    if (m_rd_data !== 32'd0)  begin errors++; $display("FAIL reset_rd_data got %h required 0", m_rd_data); end
    if (m_ref_ack !== 1'b0)   begin errors++; $display("FAIL reset_ref_ack got %b required 0", m_ref_ack); end
    if (m_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b required 1", m_req_ready); end
    #2 rst = 1'b0;
  endtask

  task automatic test_cold_miss;
    int acc;
    ev_t e, o;
    obs_q.delete(); exp_q.delete();
    present(3'd2, 14'h12, 10'h40, acc);
    push_read(acc, 1, 3'd2, 14'h12, 10'h40, bl);
    while (cyc < last_end + 3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL cold_miss_event missing cyc=%0d kind=%0d", e.cyc, e.kind); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL cold_miss_event got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                   o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL cold_miss_extra got %0d events required 0", obs_q.size()); end
  endtask

  task automatic test_row_hit;
    int acc;
    ev_t e, o;
    obs_q.delete(); exp_q.delete();
    present(3'd2, 14'h12, 10'h48, acc);
    push_read(acc, 0, 3'd2, 14'h12, 10'h48, bl);
    while (cyc < last_end + 3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL row_hit_event missing cyc=%0d kind=%0d", e.cyc, e.kind); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL row_hit_event got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                   o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL row_hit_extra got %0d events required 0", obs_q.size()); end
  endtask

  task automatic test_row_miss;
    int acc;
    ev_t e, o;
    obs_q.delete(); exp_q.delete();
    present(3'd2, 14'h13, 10'h50, acc);
    push_read(acc, 2, 3'd2, 14'h13, 10'h50, bl);
    while (cyc < last_end + 3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL row_miss_event missing cyc=%0d kind=%0d", e.cyc, e.kind); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL row_miss_event got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                   o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL row_miss_extra got %0d events required 0", obs_q.size()); end
  endtask

  task automatic test_refresh;
    int a;
    ev_t e, o;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    #2;
    ref_req = 1'b1; req_valid = 1'b1;
    req_bank = 3'd2; req_row = 14'h12; req_col = 10'h40;
    a = cyc;
    #1;
    checks++;
    if (m_req_ready !== 1'b0) begin errors++; $display("FAIL refresh_priority_ready got %b required 0", m_req_ready); end
    exp_q.push_back('{a + 1, int'(CMD_PREA), ev_val(3'd0, 14'd0)});
    exp_q.push_back('{a + 1 + t_rp, K_ACK, 32'd0});
    exp_q.push_back('{a + 2 + t_rp, K_READY, 32'd0});
    push_read(a + 2 + t_rp, 1, 3'd2, 14'h12, 10'h40, bl);
    @(negedge clk);
    #2 ref_req = 1'b0;
    repeat (t_rp + 2) @(negedge clk);
    #2 req_valid = 1'b0;
    while (cyc < last_end + 3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL refresh_event missing cyc=%0d kind=%0d", e.cyc, e.kind); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL refresh_event got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                   o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL refresh_extra got %0d events required 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_burst;
    int acc, b3;
    ev_t e, o;
    obs_q.delete(); exp_q.delete();
    present(3'd2, 14'h12, 10'h58, acc);
    push_read(acc, 0, 3'd2, 14'h12, 10'h58, 3);
    b3 = acc + 1 + cl + 3;
    while (cyc < b3) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.push_back('{b3 + 1, K_READY, 32'd0});
    @(negedge clk);
    checks += 2;
    if (m_rd_valid !== 1'b0) begin errors++; $display("FAIL midburst_rd_valid got %b required 0", m_rd_valid); end
    if (m_cmd !== 3'd0)      begin errors++; $display("FAIL midburst_cmd got %0d required 0", m_cmd); end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    present(3'd2, 14'h12, 10'h40, acc);
    push_read(acc, 1, 3'd2, 14'h12, 10'h40, bl);
    while (cyc < last_end + 3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midburst_event missing cyc=%0d kind=%0d", e.cyc, e.kind); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL midburst_event got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                   o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL midburst_extra got %0d events required 0", obs_q.size()); end
  endtask

  initial begin
    set_sel(1'b0);
    test_reset;
    test_cold_miss;
    test_row_hit;
    test_row_miss;
    test_refresh;
    test_reset_mid_burst;
    set_sel(1'b1);
    test_cold_miss;
    test_row_hit;
    test_row_miss;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
